dcache_mem_rdport: RTL



---
 rtl/dcache_mem_rdport.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dcache_mem_rdport.sv
// Memory-side burst read engine for one dcache line: issues a req/ack bus request, then forwards BURSTLEN beats.
// Optional idle-beat watchdog with sticky timeout output: define DCACHE_RDPORT_TIMEOUT_EN.
module dcache_mem_rdport #(
  parameter int unsigned BURSTLEN = 8,
  parameter int unsigned ADDRBITS = 32,
  parameter int unsigned DATABITS = 32
`ifdef DCACHE_RDPORT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 1023
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] mem_addr,
  input  logic                mem_rdreq,
  output logic [15:0]         mem_burstlen,
  output logic [DATABITS-1:0] mem_dataout,
  output logic                mem_valid,
  output logic [ADDRBITS-1:0] bus_addr,
  output logic                bus_rdreq,
  input  logic                bus_ack,
  input  logic [DATABITS-1:0] bus_rddata,
  input  logic                bus_rdvalid,
  output logic                busy,
  output logic                overrun
`ifdef DCACHE_RDPORT_TIMEOUT_EN
  , output logic              timeout
`endif
);

  localparam logic [15:0]         LAST_BEAT = 16'(BURSTLEN - 1);
  localparam logic [ADDRBITS-1:0] ALIGN     = ~ADDRBITS'(3);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t              state, state_nx;
  logic                pend_full, pend_full_nx;
  logic [ADDRBITS-1:0] pend_addr, pend_addr_nx;
  logic [15:0]         beat_cnt, beat_cnt_nx;
  logic [ADDRBITS-1:0] bus_addr_nx;
  logic                bus_rdreq_nx;
  logic [DATABITS-1:0] mem_dataout_nx;
  logic                mem_valid_nx;
  logic                busy_nx;
  logic                overrun_nx;

`ifdef DCACHE_RDPORT_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog, wdog_nx;
  logic           timeout_nx;
`endif

  assign mem_burstlen = 16'(BURSTLEN);

  // Next-state and registered-output computation
  always_comb begin
    state_nx       = state;
    pend_full_nx   = pend_full;
    pend_addr_nx   = pend_addr;
    beat_cnt_nx    = beat_cnt;
    bus_addr_nx    = bus_addr;
    bus_rdreq_nx   = bus_rdreq;
    mem_dataout_nx = mem_dataout;
    mem_valid_nx   = 1'b0;
    overrun_nx     = overrun;
`ifdef DCACHE_RDPORT_TIMEOUT_EN
    wdog_nx        = '0;
    timeout_nx     = timeout;
`endif

    case (state)
      IDLE: begin
        // A parked request wins; a simultaneous new request refills the slot.
        if (pend_full) begin
          bus_addr_nx  = pend_addr & ALIGN;
          bus_rdreq_nx = 1'b1;
          state_nx     = REQ;
          pend_full_nx = mem_rdreq;
          if (mem_rdreq) pend_addr_nx = mem_addr;
        end else if (mem_rdreq) begin
          bus_addr_nx  = mem_addr & ALIGN;
          bus_rdreq_nx = 1'b1;
          state_nx     = REQ;
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_rdreq_nx = 1'b0;
          beat_cnt_nx  = '0;
          state_nx     = DATA;
        end
      end
      DATA: begin
        if (bus_rdvalid) begin
          mem_valid_nx   = 1'b1;
          mem_dataout_nx = bus_rddata;
          beat_cnt_nx    = 16'(beat_cnt + 16'd1);
          if (beat_cnt == LAST_BEAT) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state != IDLE && mem_rdreq) begin
      if (pend_full) begin
        overrun_nx = 1'b1;
      end else begin
        pend_full_nx = 1'b1;
        pend_addr_nx = mem_addr;
      end
    end

`ifdef DCACHE_RDPORT_TIMEOUT_EN
    // Count consecutive stalled cycles; abort the transfer when the limit is hit.
    if ((state == REQ && !bus_ack) || (state == DATA && !bus_rdvalid)) begin
      if (wdog == WDW'(TIMEOUT - 1)) begin
        state_nx     = IDLE;
        bus_rdreq_nx = 1'b0;
        timeout_nx   = 1'b1;
      end else begin
        wdog_nx = WDW'(wdog + WDW'(1));
      end
    end
`endif

    busy_nx = (state_nx != IDLE) | pend_full_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend_full   <= 1'b0;
      pend_addr   <= '0;
      beat_cnt    <= '0;
      bus_addr    <= '0;
      bus_rdreq   <= 1'b0;
      mem_dataout <= '0;
      mem_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef DCACHE_RDPORT_TIMEOUT_EN
      wdog        <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      pend_full   <= pend_full_nx;
      pend_addr   <= pend_addr_nx;
      beat_cnt    <= beat_cnt_nx;
      bus_addr    <= bus_addr_nx;
      bus_rdreq   <= bus_rdreq_nx;
      mem_dataout <= mem_dataout_nx;
      mem_valid   <= mem_valid_nx;
      busy        <= busy_nx;
      overrun     <= overrun_nx;
`ifdef DCACHE_RDPORT_TIMEOUT_EN
      wdog        <= wdog_nx;
      timeout     <= timeout_nx;
`endif
    end
  end

endmodule
